// File: rtl/mem_bus_arbiter_if.sv
// Purpose : bundle of the two master request/response channels and the shared
//           memory-map port seen by mem_bus_arbiter.
// Ports   : m0_*/m1_* : req, we, addr, wdata from each master; ack, rdata back
//           bus_*     : addr, wd, we, re toward the memory map; rd back from it
// Modports: slave  - arbiter side (consumes requests, drives the memory map)
//           master - environment side (masters plus memory map model)
interface mem_bus_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  m0_req;
   logic                  m0_we;
   logic [DATA_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_wdata;
   logic                  m0_ack;
   logic [DATA_WIDTH-1:0] m0_rdata;

   logic                  m1_req;
   logic                  m1_we;
   logic [DATA_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_wdata;
   logic                  m1_ack;
   logic [DATA_WIDTH-1:0] m1_rdata;

   logic [DATA_WIDTH-1:0] bus_addr;
   logic [DATA_WIDTH-1:0] bus_wd;
   logic                  bus_we;
   logic                  bus_re;
   logic [DATA_WIDTH-1:0] bus_rd;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  bus_rd,
      output m0_ack, m0_rdata, m1_ack, m1_rdata,
      output bus_addr, bus_wd, bus_we, bus_re
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output bus_rd,
      input  m0_ack, m0_rdata, m1_ack, m1_rdata,
      input  bus_addr, bus_wd, bus_we, bus_re
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Purpose : two-master round-robin arbiter in front of the memory-map port.
//           One access at a time; the losing master waits with req held.
// Ports   : clk, rst_n (synchronous, active-low)
//           bus      - mem_bus_arbiter_if.slave (master channels + memory port)
//           busy     - high whenever the FSM is not IDLE
//           grant_id - master owning the current or last transaction
// Params  : DATA_WIDTH - address/data width
//           RD_LAT     - cycles from first bus_re to read data (0..7)
module mem_bus_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_bus_arbiter_if.slave  bus,
   output logic              busy,
   output logic              grant_id
);

   localparam int unsigned CNT_W = 3;
   // Remaining WAIT cycles after ACCESS; unused when RD_LAT is 0.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((RD_LAT == 0) ? 0 : RD_LAT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      ACK    = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  rr_last_q, rr_last_d;
   logic                  grant_q, grant_d;
   logic                  lat_we_q, lat_we_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wd_q, wd_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
   logic                  ack0_q, ack0_d;
   logic                  ack1_q, ack1_d;
   logic                  we_q, we_d;
   logic                  re_q, re_d;
   logic                  busy_q, busy_d;
   logic                  win;
   logic                  capture;

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_last_q <= 1'b1;
         grant_q   <= 1'b0;
         lat_we_q  <= 1'b0;
         cnt_q     <= '0;
         addr_q    <= '0;
         wd_q      <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         grant_q   <= grant_d;
         lat_we_q  <= lat_we_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wd_q      <= wd_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         we_q      <= we_d;
         re_q      <= re_d;
         busy_q    <= busy_d;
      end
   end

   // Next state; strobes and ack are computed for the state being entered so
   // that they are flop outputs aligned with that state.
   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      grant_d   = grant_q;
      lat_we_d  = lat_we_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wd_d      = wd_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      we_d      = 1'b0;
      re_d      = 1'b0;
      win       = 1'b0;
      capture   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               // On a tie the master not served last wins.
               win       = (bus.m0_req && bus.m1_req) ? ~rr_last_q : bus.m1_req;
               grant_d   = win;
               rr_last_d = win;
               lat_we_d  = win ? bus.m1_we    : bus.m0_we;
               addr_d    = win ? bus.m1_addr  : bus.m0_addr;
               wd_d      = win ? bus.m1_wdata : bus.m0_wdata;
               we_d      = lat_we_d;
               re_d      = ~lat_we_d;
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            if (lat_we_q) begin
               state_d = ACK;
            end else if (RD_LAT == 0) begin
               capture = 1'b1;
               state_d = ACK;
            end else begin
               cnt_d   = CNT_LOAD;
               re_d    = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               re_d  = 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Read data lands directly in the owner's rdata register.
      if (capture) begin
         if (grant_q) rdata1_d = bus.bus_rd;
         else         rdata0_d = bus.bus_rd;
      end

      if (state_d == ACK) begin
         ack0_d = ~grant_q;
         ack1_d = grant_q;
      end

      busy_d = (state_d != IDLE);
   end

   assign bus.m0_ack   = ack0_q;
   assign bus.m1_ack   = ack1_q;
   assign bus.m0_rdata = rdata0_q;
   assign bus.m1_rdata = rdata1_q;
   assign bus.bus_addr = addr_q;
   assign bus.bus_wd   = wd_q;
   assign bus.bus_we   = we_q;
   assign bus.bus_re   = re_q;
   assign busy         = busy_q;
   assign grant_id     = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose : self-checking bench for mem_bus_arbiter. dut_a runs with RD_LAT=3
//           and carries most scenarios; dut_b runs with RD_LAT=1 for the short
//           read case. The memory model returns valid data only in the last
//           bus_re cycle, so an early or late capture reads garbage.
module tb_mem_bus_arbiter;
   localparam int DW    = 32;
   localparam int LAT_A = 3;
   localparam int LAT_B = 1;

   logic clk = 1'b0;
   logic rst_n;
   logic busy_a, grant_a, busy_b, grant_b;
   int   errors = 0;
   int   checks = 0;
   int unsigned re_run_a = 0;
   int unsigned re_run_b = 0;

   mem_bus_arbiter_if #(.DATA_WIDTH(DW)) ba ();
   mem_bus_arbiter_if #(.DATA_WIDTH(DW)) bb ();

   mem_bus_arbiter #(.DATA_WIDTH(DW), .RD_LAT(LAT_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ba.slave), .busy(busy_a), .grant_id(grant_a));
   mem_bus_arbiter #(.DATA_WIDTH(DW), .RD_LAT(LAT_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bb.slave), .busy(busy_b), .grant_id(grant_b));

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h1001_0000) return 32'h1234_5678;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   // Memory map: data valid only RD_LAT cycles after the first bus_re cycle.
   always @(posedge clk) re_run_a <= ba.bus_re ? re_run_a + 1 : 0;
   always @(posedge clk) re_run_b <= bb.bus_re ? re_run_b + 1 : 0;
   assign ba.bus_rd = (ba.bus_re && re_run_a == LAT_A) ? mem_val(ba.bus_addr) : (32'hBAD0_0000 | re_run_a);
   assign bb.bus_rd = (bb.bus_re && re_run_b == LAT_B) ? mem_val(bb.bus_addr) : (32'hBAD0_0000 | re_run_b);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input int m, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      if (m == 0) begin
         ba.m0_req = r; ba.m0_we = w; ba.m0_addr = a; ba.m0_wdata = d;
      end else begin
         ba.m1_req = r; ba.m1_we = w; ba.m1_addr = a; ba.m1_wdata = d;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_a(0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0011);
      drive_a(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
      repeat (3) tick();
      checks++;
      if ({ba.m0_ack, ba.m1_ack, ba.bus_we, ba.bus_re, busy_a, grant_a} !== 6'b0) begin
         errors++; $display("FAIL reset_ctl: got %b want 000000", {ba.m0_ack, ba.m1_ack, ba.bus_we, ba.bus_re, busy_a, grant_a});
      end
      checks++;
      if (ba.m0_rdata !== 32'h0 || ba.m1_rdata !== 32'h0 || ba.bus_addr !== 32'h0 || ba.bus_wd !== 32'h0) begin
         errors++; $display("FAIL reset_data: got rd0=%h rd1=%h addr=%h wd=%h want all 0", ba.m0_rdata, ba.m1_rdata, ba.bus_addr, ba.bus_wd);
      end
      checks++;
      if ({bb.m0_ack, bb.m1_ack, bb.bus_we, bb.bus_re, busy_b, grant_b} !== 6'b0 || bb.m1_rdata !== 32'h0) begin
         errors++; $display("FAIL reset_b: got %b rd1=%h want 0", {bb.m0_ack, bb.m1_ack, bb.bus_we, bb.bus_re, busy_b, grant_b}, bb.m1_rdata);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({grant_a, ba.bus_we, ba.bus_re, busy_a} !== 4'b0101 || ba.bus_addr !== 32'h100 || ba.bus_wd !== 32'h11) begin
         errors++; $display("FAIL first_grant: got g/we/re/busy=%b addr=%h wd=%h want 0101 100 11", {grant_a, ba.bus_we, ba.bus_re, busy_a}, ba.bus_addr, ba.bus_wd);
      end
      tick();
      checks++;
      if ({ba.m0_ack, ba.m1_ack} !== 2'b10) begin
         errors++; $display("FAIL first_ack: got %b want 10", {ba.m0_ack, ba.m1_ack});
      end
      ba.m0_req = 1'b0;
      tick();
      tick();
      checks++;
      if ({grant_a, ba.bus_re} !== 2'b11) begin
         errors++; $display("FAIL second_grant: got %b want 11", {grant_a, ba.bus_re});
      end
      repeat (4) tick();
      checks++;
      if (ba.m1_ack !== 1'b1 || ba.m1_rdata !== mem_val(32'h200)) begin
         errors++; $display("FAIL second_ack: got ack=%b rd=%h want 1 %h", ba.m1_ack, ba.m1_rdata, mem_val(32'h200));
      end
      ba.m1_req = 1'b0;
      tick();
   endtask

   task automatic test_single_write();
      drive_a(0, 1'b1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if ({ba.bus_we, ba.bus_re, ba.m0_ack, ba.m1_ack} !== {(k == 1), 1'b0, (k == 2), 1'b0}) begin
            errors++; $display("FAIL write_k%0d: got we/re/a0/a1=%b want %b", k, {ba.bus_we, ba.bus_re, ba.m0_ack, ba.m1_ack}, {(k == 1), 1'b0, (k == 2), 1'b0});
         end
         if (k == 1) begin
            checks++;
            if (ba.bus_addr !== 32'h1000_0004 || ba.bus_wd !== 32'hDEAD_BEEF) begin
               errors++; $display("FAIL write_bus: got %h/%h want 10000004/deadbeef", ba.bus_addr, ba.bus_wd);
            end
         end
         if (k == 2) ba.m0_req = 1'b0;
      end
   endtask

   task automatic test_read_lat3();
      drive_a(1, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++;
         if ({ba.bus_re, ba.bus_we, ba.m0_ack, ba.m1_ack} !== {(k <= 4), 1'b0, 1'b0, (k == 5)}) begin
            errors++; $display("FAIL read3_k%0d: got re/we/a0/a1=%b want %b", k, {ba.bus_re, ba.bus_we, ba.m0_ack, ba.m1_ack}, {(k <= 4), 1'b0, 1'b0, (k == 5)});
         end
         if (k == 5) begin
            checks++;
            if (ba.m1_rdata !== 32'h1234_5678) begin
               errors++; $display("FAIL read3_data: got %h want 12345678", ba.m1_rdata);
            end
            ba.m1_req = 1'b0;
         end
      end
   endtask

   task automatic test_read_lat1();
      bb.m1_req = 1'b1; bb.m1_we = 1'b0; bb.m1_addr = 32'h1001_0000; bb.m1_wdata = 32'h0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if ({bb.bus_re, bb.m0_ack, bb.m1_ack, grant_b} !== {(k <= 2), 1'b0, (k == 3), (k >= 1)}) begin
            errors++; $display("FAIL read1_k%0d: got re/a0/a1/g=%b want %b", k, {bb.bus_re, bb.m0_ack, bb.m1_ack, grant_b}, {(k <= 2), 1'b0, (k == 3), 1'b1});
         end
         if (k == 3) begin
            checks++;
            if (bb.m1_rdata !== 32'h1234_5678 || bb.m0_rdata !== 32'h0) begin
               errors++; $display("FAIL read1_data: got rd1=%h rd0=%h want 12345678 0", bb.m1_rdata, bb.m0_rdata);
            end
            bb.m1_req = 1'b0;
         end
      end
   endtask

   task automatic test_late_request();
      logic [3:0] exp;
      drive_a(0, 1'b1, 1'b0, 32'h2000_0040, 32'h0);
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp = {(k >= 1 && k <= 4), (k == 7), (k == 5), (k == 8)};
         checks++;
         if ({ba.bus_re, ba.bus_we, ba.m0_ack, ba.m1_ack} !== exp || grant_a !== (k >= 7)) begin
            errors++; $display("FAIL late_k%0d: got re/we/a0/a1=%b g=%b want %b g=%b", k, {ba.bus_re, ba.bus_we, ba.m0_ack, ba.m1_ack}, grant_a, exp, (k >= 7));
         end
         if (ba.bus_re) begin
            checks++;
            if (ba.bus_addr !== 32'h2000_0040) begin
               errors++; $display("FAIL late_addr_k%0d: got %h want 20000040", k, ba.bus_addr);
            end
         end
         if (k == 7) begin
            checks++;
            if (ba.bus_addr !== 32'h3000_0008 || ba.bus_wd !== 32'hCAFE_F00D) begin
               errors++; $display("FAIL late_m1_bus: got %h/%h want 30000008/cafef00d", ba.bus_addr, ba.bus_wd);
            end
         end
         if (k == 2) drive_a(1, 1'b1, 1'b1, 32'h3000_0008, 32'hCAFE_F00D);
         if (k == 5) begin
            checks++;
            if (ba.m0_rdata !== mem_val(32'h2000_0040)) begin
               errors++; $display("FAIL late_m0_data: got %h want %h", ba.m0_rdata, mem_val(32'h2000_0040));
            end
            ba.m0_req = 1'b0;
         end
         if (k == 8) ba.m1_req = 1'b0;
      end
   endtask

   task automatic test_reset_mid_read();
      drive_a(0, 1'b1, 1'b0, 32'h0400_0010, 32'h0);
      tick();
      tick();
      rst_n = 1'b0;
      for (int k = 3; k <= 4; k++) begin
         tick();
         checks++;
         if ({ba.bus_re, ba.m0_ack, ba.m1_ack, busy_a} !== 4'b0 || ba.m0_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_k%0d: got re/a0/a1/busy=%b rd0=%h want 0000 0", k, {ba.bus_re, ba.m0_ack, ba.m1_ack, busy_a}, ba.m0_rdata);
         end
      end
      rst_n = 1'b1;
      for (int k = 5; k <= 10; k++) begin
         tick();
         checks++;
         if ({ba.bus_re, ba.m0_ack, ba.m1_ack} !== {(k <= 8), (k == 9), 1'b0}) begin
            errors++; $display("FAIL rst_resume_k%0d: got %b want %b", k, {ba.bus_re, ba.m0_ack, ba.m1_ack}, {(k <= 8), (k == 9), 1'b0});
         end
         if (k == 9) begin
            checks++;
            if (ba.m0_rdata !== mem_val(32'h0400_0010)) begin
               errors++; $display("FAIL rst_resume_data: got %h want %h", ba.m0_rdata, mem_val(32'h0400_0010));
            end
            ba.m0_req = 1'b0;
         end
      end
   endtask

   task automatic test_contention();
      logic        tw [2][4];
      logic [31:0] ta [2][4];
      logic [31:0] td [2][4];
      int          idx [2];
      int          exp_m, acks, who;
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 4; i++) begin
            tw[m][i] = 1'($urandom);
            ta[m][i] = $urandom & 32'hFFFF_FFFC;
            td[m][i] = $urandom;
         end
      idx = '{0, 0};
      exp_m = 0; acks = 0; who = 0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      drive_a(0, 1'b1, tw[0][0], ta[0][0], td[0][0]);
      drive_a(1, 1'b1, tw[1][0], ta[1][0], td[1][0]);
      for (int c = 0; c < 200 && acks < 8; c++) begin
         tick();
         checks++;
         if (ba.m0_ack && ba.m1_ack) begin
            errors++; $display("FAIL cont_dual_ack: got both acks want one");
         end
         if (ba.bus_we && idx[exp_m] < 4) begin
            checks++;
            if (ba.bus_addr !== ta[exp_m][idx[exp_m]] || ba.bus_wd !== td[exp_m][idx[exp_m]]) begin
               errors++; $display("FAIL cont_wbus: got %h/%h want %h/%h", ba.bus_addr, ba.bus_wd, ta[exp_m][idx[exp_m]], td[exp_m][idx[exp_m]]);
            end
         end
         if ((ba.m0_ack || ba.m1_ack) && !(ba.m0_ack && ba.m1_ack)) begin
            who = ba.m1_ack ? 1 : 0;
            checks++;
            if (who != exp_m) begin
               errors++; $display("FAIL cont_order: got m%0d want m%0d at ack %0d", who, exp_m, acks);
            end
            if (idx[who] < 4 && !tw[who][idx[who]]) begin
               checks++;
               if ((who == 1 ? ba.m1_rdata : ba.m0_rdata) !== mem_val(ta[who][idx[who]])) begin
                  errors++; $display("FAIL cont_rdata: got %h want %h", (who == 1 ? ba.m1_rdata : ba.m0_rdata), mem_val(ta[who][idx[who]]));
               end
            end
            idx[who]++;
            acks++;
            if (idx[who] < 4) drive_a(who, 1'b1, tw[who][idx[who]], ta[who][idx[who]], td[who][idx[who]]);
            else              drive_a(who, 1'b0, 1'b0, 32'h0, 32'h0);
            exp_m = 1 - exp_m;
         end
      end
      checks++;
      if (acks != 8) begin
         errors++; $display("FAIL cont_count: got %0d acks want 8", acks);
      end
      drive_a(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_a(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
   endtask

   // Random traffic against a transaction-level model: each grant is fixed by
   // the round-robin rule at its sample cycle S, and every output is then a
   // function of S and the access latency.
   task automatic test_random();
      int          left [2];
      int          gap [2];
      logic        rq [2];
      logic        w [2];
      logic [31:0] a [2];
      logic [31:0] d [2];
      logic [31:0] exp_rd [2];
      bit          cur_v, fin;
      int          cur_m, s, ack_c, free_c, rr, g_exp;
      logic        e_we, e_re, e_a0, e_a1, e_busy;
      rst_n = 1'b0;
      drive_a(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_a(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      left = '{12, 12}; gap = '{0, 2}; rq = '{1'b0, 1'b0};
      w = '{1'b0, 1'b0}; a = '{32'h0, 32'h0}; d = '{32'h0, 32'h0}; exp_rd = '{32'h0, 32'h0};
      cur_v = 0; fin = 0; cur_m = 0; s = 0; ack_c = 0; free_c = 0; rr = 1; g_exp = 0;
      for (int c = 0; c < 1000 && !fin; c++) begin
         if (c > 0) tick();
         if (cur_v && c == s + 1) g_exp = cur_m;
         if (cur_v && c == ack_c && !w[cur_m]) exp_rd[cur_m] = mem_val(a[cur_m]);
         e_we   = cur_v && w[cur_m] && c == s + 1;
         e_re   = cur_v && !w[cur_m] && c > s && c <= s + 1 + LAT_A;
         e_a0   = cur_v && c == ack_c && cur_m == 0;
         e_a1   = cur_v && c == ack_c && cur_m == 1;
         e_busy = cur_v && c > s && c <= ack_c;
         checks++;
         if ({ba.bus_we, ba.bus_re, ba.m0_ack, ba.m1_ack, busy_a, grant_a} !== {e_we, e_re, e_a0, e_a1, e_busy, 1'(g_exp)}) begin
            errors++; $display("FAIL rand_ctl_c%0d: got we/re/a0/a1/busy/g=%b want %b", c, {ba.bus_we, ba.bus_re, ba.m0_ack, ba.m1_ack, busy_a, grant_a}, {e_we, e_re, e_a0, e_a1, e_busy, 1'(g_exp)});
         end
         checks++;
         if (ba.m0_rdata !== exp_rd[0] || ba.m1_rdata !== exp_rd[1]) begin
            errors++; $display("FAIL rand_rdata_c%0d: got %h/%h want %h/%h", c, ba.m0_rdata, ba.m1_rdata, exp_rd[0], exp_rd[1]);
         end
         if (e_we || e_re) begin
            checks++;
            if (ba.bus_addr !== a[cur_m] || (e_we && ba.bus_wd !== d[cur_m])) begin
               errors++; $display("FAIL rand_bus_c%0d: got %h/%h want %h/%h", c, ba.bus_addr, ba.bus_wd, a[cur_m], d[cur_m]);
            end
         end
         if (cur_v && c == ack_c) begin
            rq[cur_m] = 1'b0;
            left[cur_m]--;
            gap[cur_m] = $urandom_range(0, 4);
            cur_v = 0;
            free_c = c + 1;
         end
         for (int m = 0; m < 2; m++) begin
            if (!rq[m] && left[m] > 0) begin
               if (gap[m] == 0) begin
                  rq[m] = 1'b1;
                  w[m]  = 1'($urandom);
                  a[m]  = $urandom & 32'hFFFF_FFFC;
                  d[m]  = $urandom;
               end else begin
                  gap[m]--;
               end
            end
         end
         drive_a(0, rq[0], w[0], a[0], d[0]);
         drive_a(1, rq[1], w[1], a[1], d[1]);
         if (!cur_v && c >= free_c && (rq[0] || rq[1])) begin
            cur_m = (rq[0] && rq[1]) ? 1 - rr : (rq[1] ? 1 : 0);
            rr    = cur_m;
            s     = c;
            ack_c = c + 2 + (w[cur_m] ? 0 : LAT_A);
            cur_v = 1;
         end
         if (left[0] == 0 && left[1] == 0 && !cur_v) fin = 1;
      end
      checks++;
      if (!fin) begin
         errors++; $display("FAIL rand_timeout: got left=%0d/%0d want 0/0", left[0], left[1]);
      end
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      drive_a(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_a(1, 1'b0, 1'b0, 32'h0, 32'h0);
      bb.m0_req = 1'b0; bb.m0_we = 1'b0; bb.m0_addr = 32'h0; bb.m0_wdata = 32'h0;
      bb.m1_req = 1'b0; bb.m1_we = 1'b0; bb.m1_addr = 32'h0; bb.m1_wdata = 32'h0;
      test_reset();
      test_single_write();
      test_read_lat3();
      test_read_lat1();
      test_late_request();
      test_reset_mid_read();
      test_contention();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion want finish before 400000");
      $fatal(1, "watchdog");
   end
endmodule
